sad_pingpong_frame_buffer: RTL

Parametrised double-buffered line store for the SAD processor. The writer streams lines sequentially into one bank while the reader randomly addresses a completed frame in the other bank. Banks swap under an explicit release handshake, so a frame is never overwritten while it is still being read. It replaces the single-bank line RAM, which had no backpressure and no frame hand-off.

---
 rtl/sad_fb_pkg.sv | 17 +
 rtl/sad_pingpong_frame_buffer_if.sv | 32 +++
 rtl/sad_line_ram.sv | 29 ++
 rtl/sad_pingpong_frame_buffer.sv | 113 +++++++++++
 4 files changed

// File: rtl/sad_fb_pkg.sv
// Shared types and sizing for the SAD ping-pong line store.
// Bank occupancy enum, image geometry and the line-address width helper.
package sad_fb_pkg;

  typedef enum logic {
    FREE = 1'b0,
    FULL = 1'b1
  } bank_state_t;

  localparam int SAD_ROW_W = 640;
  localparam int SAD_COL_D = 480;

  function automatic int sad_addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/sad_pingpong_frame_buffer_if.sv
// Writer/reader signal bundle of the ping-pong frame buffer.
// The master side is the producer/consumer pair, the slave side is the buffer.
interface sad_pingpong_frame_buffer_if
  import sad_fb_pkg::*;
#(
  parameter int DATA_W = SAD_ROW_W,
  parameter int ADDR_W = sad_addr_w(SAD_COL_D)
);

  logic              wr_valid;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;
  logic              wr_frame_done;
  logic              rd_frame_avail;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              rd_err;
  logic              rd_release;

  modport master (
    output wr_valid, wr_data, rd_en, rd_addr, rd_release,
    input  wr_ready, wr_frame_done, rd_frame_avail, rd_data, rd_valid, rd_err
  );

  modport slave (
    input  wr_valid, wr_data, rd_en, rd_addr, rd_release,
    output wr_ready, wr_frame_done, rd_frame_avail, rd_data, rd_valid, rd_err
  );

endinterface

// File: rtl/sad_line_ram.sv
// One bank of the line store: single write port, registered read port.
// Only the read register is reset; the array contents are left as-is.
module sad_line_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/sad_pingpong_frame_buffer.sv
// Double-buffered line store: writer fills one bank while the reader owns the other.
// Banks change hands only on a completed fill or an explicit reader release.
//
//   bank state | meaning
//   FREE       | bank may be filled by the writer
//   FULL       | bank holds a complete frame, owned by the reader until release
module sad_pingpong_frame_buffer
  import sad_fb_pkg::*;
#(
  parameter  int DATA_W = SAD_ROW_W,
  parameter  int DEPTH  = SAD_COL_D,
  localparam int ADDR_W = sad_addr_w(DEPTH)
) (
  input logic clk,
  input logic rst,
  sad_pingpong_frame_buffer_if.slave bus
);

  bank_state_t       bank_st   [2];
  bank_state_t       bank_st_n [2];
  logic              wr_bank, wr_bank_n, rd_bank, rd_bank_n;
  logic [ADDR_W-1:0] wr_addr, wr_addr_n;
  logic              done_q, done_n, rd_valid_q, rd_valid_n;
  logic              err_q, err_n, sel_q, sel_n;
  logic              fill_free, read_full, wr_acc, wr_last, rd_acc, in_range, rel;
  logic [DATA_W-1:0] ram_rdata [2];

  assign fill_free = (bank_st[wr_bank] == FREE);
  assign read_full = (bank_st[rd_bank] == FULL);
  assign wr_acc    = bus.wr_valid && fill_free;
  assign wr_last   = wr_acc && (wr_addr == ADDR_W'(DEPTH - 1));
  assign rd_acc    = bus.rd_en && read_full;
  assign in_range  = {1'b0, bus.rd_addr} < (ADDR_W + 1)'(DEPTH);
  assign rel       = bus.rd_release && read_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      bank_st[0] <= FREE;
      bank_st[1] <= FREE;
      wr_bank    <= 1'b0;
      rd_bank    <= 1'b0;
      wr_addr    <= '0;
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
      sel_q      <= 1'b0;
    end else begin
      bank_st[0] <= bank_st_n[0];
      bank_st[1] <= bank_st_n[1];
      wr_bank    <= wr_bank_n;
      rd_bank    <= rd_bank_n;
      wr_addr    <= wr_addr_n;
      done_q     <= done_n;
      rd_valid_q <= rd_valid_n;
      err_q      <= err_n;
      sel_q      <= sel_n;
    end
  end

  // A completing fill and a release always target different banks, so both may apply.
  always_comb begin
    bank_st_n[0] = bank_st[0];
    bank_st_n[1] = bank_st[1];
    wr_bank_n    = wr_bank;
    rd_bank_n    = rd_bank;
    wr_addr_n    = wr_addr;
    done_n       = wr_last;
    rd_valid_n   = rd_acc;
    err_n        = err_q;
    sel_n        = sel_q;
    if (wr_acc) wr_addr_n = wr_addr + ADDR_W'(1);
    if (wr_last) begin
      wr_addr_n          = '0;
      bank_st_n[wr_bank] = FULL;
      wr_bank_n          = ~wr_bank;
    end
    if (rel) begin
      bank_st_n[rd_bank] = FREE;
      rd_bank_n          = ~rd_bank;
    end
    if (rd_acc) begin
      err_n = ~in_range;
      sel_n = rd_bank;
    end
  end

  always_comb begin
    bus.wr_ready       = fill_free;
    bus.rd_frame_avail = read_full;
    bus.wr_frame_done  = done_q;
    bus.rd_valid       = rd_valid_q;
    bus.rd_err         = rd_valid_q & err_q;
    bus.rd_data        = err_q ? '0 : ram_rdata[sel_q];
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    sad_line_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
    ) u_ram (
      .clk   (clk),
      .rst   (rst),
      .we    (wr_acc && (wr_bank == 1'(b))),
      .waddr (wr_addr),
      .wdata (bus.wr_data),
      .re    (rd_acc && in_range && (rd_bank == 1'(b))),
      .raddr (bus.rd_addr),
      .rdata (ram_rdata[b])
    );
  end

endmodule
